// File: rtl/riscv_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_alu_pkg
// Description : Shared definitions for the RV32I/RV32M execute-stage ALU
//               control decoder: ALU control codes, opcode and funct7
//               constants, divider state encoding, and the decode function.
//               ALU control code format is {m, alt, funct3}.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_alu_pkg;

    // ALU control codes
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;

    // M-extension codes are this prefix followed by funct3
    localparam logic [1:0] ALU_M_PREFIX = 2'b10;

    // Opcodes
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // Divider sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic [4:0] code;
        logic       mdu;
        logic       illegal;
    } alu_dec_t;

    // Base (non-alt) operation code selected purely by funct3
    function automatic logic [4:0] base_code(input logic [2:0] f3);
        logic [4:0] code;
        case (f3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    // Full decode. Any illegal combination reports code ADD so the datapath
    // never sees a stray shift or subtract for a trapped instruction.
    function automatic alu_dec_t alu_decode(
        input logic [1:0] alu_op,
        input logic [6:0] op,
        input logic [2:0] f3,
        input logic [6:0] f7,
        input logic       mext_en
    );
        alu_dec_t dec;
        dec.code    = ALU_ADD;
        dec.mdu     = 1'b0;
        dec.illegal = 1'b0;
        case (alu_op)
            2'b00: dec.code = ALU_ADD;
            2'b01: dec.code = ALU_SUB;
            2'b10: begin
                if (op == OP_R) begin
                    if (f7 == F7_BASE) begin
                        dec.code = base_code(f3);
                    end else if (f7 == F7_ALT && f3 == 3'b000) begin
                        dec.code = ALU_SUB;
                    end else if (f7 == F7_ALT && f3 == 3'b101) begin
                        dec.code = ALU_SRA;
                    end else if (f7 == F7_MEXT && mext_en) begin
                        dec.code = {ALU_M_PREFIX, f3};
                        dec.mdu  = 1'b1;
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end else begin
                    // Immediate forms: funct7 only matters for shifts, where
                    // it is the upper immediate field (shamt qualifier).
                    case (f3)
                        3'b001: begin
                            if (f7 == F7_BASE) dec.code    = ALU_SLL;
                            else               dec.illegal = 1'b1;
                        end
                        3'b101: begin
                            if (f7 == F7_BASE)     dec.code    = ALU_SRL;
                            else if (f7 == F7_ALT) dec.code    = ALU_SRA;
                            else                   dec.illegal = 1'b1;
                        end
                        default: dec.code = base_code(f3);
                    endcase
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.code = ALU_ADD;
        end
        return dec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_unit
// Description : Unsigned restoring-division datapath, one quotient bit per
//               step. Holds divisor, partial remainder and the shifting
//               dividend/quotient register. Exposes the next-step values so
//               the controller can capture the final result on the same edge
//               as the last step.
// Ports       : clk, rst (async, active-high)
//               i_load      - capture i_dividend / i_divisor, clear remainder
//               i_step      - perform one restoring step
//               i_dividend  - unsigned dividend magnitude
//               i_divisor   - unsigned divisor magnitude (non-zero)
//               o_quotient_next / o_remainder_next - result of the next step
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quotient_next,
    output logic [XLEN-1:0] o_remainder_next
);

    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN:0]   w_trial;

    // Shift the next dividend bit into the remainder and try subtracting.
    // The extra top bit is the borrow: set means the divisor did not fit.
    assign w_trial          = {r_rem, r_quo[XLEN-1]} - {1'b0, r_dvs};
    assign o_quotient_next  = {r_quo[XLEN-2:0], ~w_trial[XLEN]};
    assign o_remainder_next = w_trial[XLEN] ? {r_rem[XLEN-2:0], r_quo[XLEN-1]}
                                            : w_trial[XLEN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
        end else if (i_load) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_dvs <= i_divisor;
        end else if (i_step) begin
            r_quo <= o_quotient_next;
            r_rem <= o_remainder_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_mdu_ctrl
// Description : Registered ALU control decoder for the RV32I/RV32M execute
//               stage with a multi-cycle signed/unsigned divider sequencer.
//               Decode results appear one cycle after acceptance; divides
//               stall the pipeline for XLEN cycles, special cases (divide by
//               zero, signed overflow) complete in one cycle.
// Config      : define ALU_MDU_CTRL_MEXT_EN to include M-extension decode and
//               the divider. Without it funct7=0000001 is illegal, In_ready
//               is tied high and Stall/Div_valid/Div_result are tied low.
// Ports       : CLK, RST (async, active-high)
//               In_valid/In_ready      - decode request handshake
//               ALU_OP, OP, Func3, Func7 - decode inputs
//               Rs1_data, Rs2_data     - dividend / divisor
//               ALU_control, Ctrl_valid, Mdu_sel, Illegal - decode outputs
//               Stall                  - divide in progress
//               Div_result, Div_valid  - divider result
//               XLEN must be at least 8.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu_ctrl
    import riscv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            In_valid,
    output logic            In_ready,
    input  logic [1:0]      ALU_OP,
    input  logic [6:0]      OP,
    input  logic [2:0]      Func3,
    input  logic [6:0]      Func7,
    input  logic [XLEN-1:0] Rs1_data,
    input  logic [XLEN-1:0] Rs2_data,
    output logic [4:0]      ALU_control,
    output logic            Ctrl_valid,
    output logic            Mdu_sel,
    output logic            Illegal,
    output logic            Stall,
    output logic [XLEN-1:0] Div_result,
    output logic            Div_valid
);

`ifdef ALU_MDU_CTRL_MEXT_EN
    localparam logic c_mext_en = 1'b1;
`else
    localparam logic c_mext_en = 1'b0;
`endif

    alu_dec_t w_dec;
    logic     w_accept;

    assign w_dec    = alu_decode(ALU_OP, OP, Func3, Func7, c_mext_en);
    assign w_accept = In_valid && In_ready;

    // Decode register: outputs hold until the next accepted request
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ALU_control <= ALU_ADD;
            Mdu_sel     <= 1'b0;
            Illegal     <= 1'b0;
            Ctrl_valid  <= 1'b0;
        end else begin
            Ctrl_valid <= w_accept;
            if (w_accept) begin
                ALU_control <= w_dec.code;
                Mdu_sel     <= w_dec.mdu;
                Illegal     <= w_dec.illegal;
            end
        end
    end

`ifdef ALU_MDU_CTRL_MEXT_EN
    localparam int             CW           = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0]  c_count_init = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] c_int_min   = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      r_state;
    div_state_t      w_state_next;
    logic [CW-1:0]   r_count;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_want_rem;

    logic            w_is_div;
    logic            w_signed;
    logic            w_want_rem;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic            w_div_start;
    logic            w_div_special;
    logic            w_step;
    logic            w_last_step;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN-1:0] w_q_next;
    logic [XLEN-1:0] w_r_next;
    logic [XLEN-1:0] w_fixed_res;

    // funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
    assign w_is_div   = w_dec.mdu && Func3[2];
    assign w_signed   = ~Func3[0];
    assign w_want_rem = Func3[1];

    assign w_div_zero = (Rs2_data == '0);
    assign w_ovf      = w_signed && (Rs1_data == c_int_min) && (&Rs2_data);
    assign w_special  = w_div_zero || w_ovf;

    assign w_div_start   = w_accept && w_is_div && !w_special;
    assign w_div_special = w_accept && w_is_div && w_special;

    // Architectural results for the cases the iterative datapath cannot do
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = w_want_rem ? Rs1_data : {XLEN{1'b1}};
        end else begin
            w_special_res = w_want_rem ? '0 : Rs1_data;
        end
    end

    // Magnitudes; INT_MIN negates to itself, which is its correct
    // unsigned magnitude.
    assign w_a_mag = (w_signed && Rs1_data[XLEN-1]) ? -Rs1_data : Rs1_data;
    assign w_b_mag = (w_signed && Rs2_data[XLEN-1]) ? -Rs2_data : Rs2_data;

    assign w_step      = (r_state == ST_DIV);
    assign w_last_step = w_step && (r_count == '0);

    div_iter_unit #(
        .XLEN (XLEN)
    ) u_div_iter (
        .clk              (CLK),
        .rst              (RST),
        .i_load           (w_div_start),
        .i_step           (w_step),
        .i_dividend       (w_a_mag),
        .i_divisor        (w_b_mag),
        .o_quotient_next  (w_q_next),
        .o_remainder_next (w_r_next)
    );

    // Sign fix-up applied to the value produced by the final step
    always_comb begin
        w_fixed_res = '0;
        if (r_want_rem) begin
            w_fixed_res = r_neg_r ? -w_r_next : w_r_next;
        end else begin
            w_fixed_res = r_neg_q ? -w_q_next : w_q_next;
        end
    end

    // In_ready is kept out of the FSM process: the accept term feeds the
    // next-state logic, and merging them would form a combinational loop.
    assign In_ready = (r_state != ST_DIV);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        Stall        = 1'b0;
        Div_valid    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                Div_valid = (r_state == ST_DONE);
                if (w_div_start) begin
                    w_state_next = ST_DIV;
                end else if (w_div_special) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DIV: begin
                Stall = 1'b1;
                if (r_count == '0) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count    <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_want_rem <= 1'b0;
            Div_result <= '0;
        end else begin
            if (w_div_start) begin
                r_count    <= c_count_init;
                r_neg_q    <= w_signed && (Rs1_data[XLEN-1] ^ Rs2_data[XLEN-1]);
                r_neg_r    <= w_signed && Rs1_data[XLEN-1];
                r_want_rem <= w_want_rem;
            end else if (w_step && r_count != '0) begin
                r_count <= r_count - 1'b1;
            end

            if (w_div_special) begin
                Div_result <= w_special_res;
            end else if (w_last_step) begin
                Div_result <= w_fixed_res;
            end
        end
    end
`else
    logic w_unused_ops;

    assign w_unused_ops = ^{Rs1_data, Rs2_data};
    assign In_ready     = 1'b1;
    assign Stall        = 1'b0;
    assign Div_valid    = 1'b0;
    assign Div_result   = '0;
`endif

endmodule
`default_nettype wire
